// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port data memory between the pipeline MEM
//               stage (CPU port) and a debug/loader port (DBG port). One
//               access is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
//               The winner's command is captured in IDLE, presented to the
//               memory for one ISSUE cycle, read data is captured after
//               MEM_LATENCY cycles and the access completes with a one-cycle
//               rvalid pulse in RESP.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DATA_W       data word width
//               ADDR_W       byte address width (passed to memory unchanged)
//               MEM_LATENCY  cycles from mem_en to valid mem_rdata (>= 1)
// Ports       : clk                          rising-edge clock
//               reset                        asynchronous, active-low reset
//               cpu_req/we/addr/wdata        CPU command (held until cpu_gnt)
//               cpu_gnt                      1-cycle pulse, command captured
//               cpu_rvalid                   1-cycle pulse, access complete
//               cpu_rdata                    CPU read data, held after rvalid
//               cpu_stall                    pipeline stall request
//               dbg_*                        DBG equivalents of the CPU ports
//               mem_en/we/addr/wdata         memory command
//               mem_rdata                    memory read data
// Build macro : DMEM_ARB_RR_EN - when defined, ties are resolved round-robin
//               against the last owner; otherwise the CPU always wins ties.
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic            OWN_CPU  = 1'b0;
  localparam logic            OWN_DBG  = 1'b1;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                owner_q,     owner_d;    // doubles as last_owner
  logic                cmd_we_q,    cmd_we_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_gnt_q,   cpu_gnt_d;
  logic                dbg_gnt_q,   dbg_gnt_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

  logic win_dbg;
  logic cpu_active;

  // Winner selection, only consulted in IDLE when at least one req is high.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    // On a tie the port that did not own the previous access wins.
    win_dbg = cpu_req ? (dbg_req & (owner_q == OWN_CPU)) : 1'b1;
`else
    win_dbg = ~cpu_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    cmd_we_d     = cmd_we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req | dbg_req) begin
          // Outputs are registered, so the ISSUE-cycle values are loaded here.
          state_d     = ST_ISSUE;
          owner_d     = win_dbg ? OWN_DBG : OWN_CPU;
          cmd_we_d    = win_dbg ? dbg_we    : cpu_we;
          mem_addr_d  = win_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
          mem_we_d    = win_dbg ? dbg_we    : cpu_we;
          mem_en_d    = 1'b1;
          cpu_gnt_d   = ~win_dbg;
          dbg_gnt_d   = win_dbg;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_DBG) begin
            dbg_rvalid_d = 1'b1;
            if (!cmd_we_q) dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rvalid_d = 1'b1;
            if (!cmd_we_q) cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_DBG;
      cmd_we_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      cmd_we_q     <= cmd_we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // The CPU owns the in-flight access whenever the FSM is busy on its behalf;
  // otherwise a raised cpu_req simply stalls until it is served. Gated by
  // reset so the stall output is also 0 while reset is held.
  assign cpu_active = (owner_q == OWN_CPU) && (state_q != ST_IDLE);
  assign cpu_stall  = reset & (cpu_active ? ((state_q == ST_ISSUE) || (state_q == ST_WAIT))
                                          : (cpu_req & ~cpu_rvalid_q));

  assign cpu_gnt    = cpu_gnt_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Two DUTs are built
//               (MEM_LATENCY 1 and 3), each with its own memory model, and
//               exercised one after the other. Expected behaviour comes from
//               a transaction/timing model: a captured access at edge E gives
//               gnt in cycle E+1, rvalid in E+2+L and frees the arbiter for
//               sampling again at the end of cycle E+L+3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req [2];
  logic        cpu_we [2];
  logic [31:0] cpu_addr [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_gnt [2];
  logic        cpu_rvalid [2];
  logic [31:0] cpu_rdata [2];
  logic        cpu_stall [2];
  logic        dbg_req [2];
  logic        dbg_we [2];
  logic [31:0] dbg_addr [2];
  logic [31:0] dbg_wdata [2];
  logic        dbg_gnt [2];
  logic        dbg_rvalid [2];
  logic [31:0] dbg_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h0000_0055 : (32'hC0DE_0000 | 32'(i));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int GL = (g == 0) ? 1 : 3;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(GL)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_gnt   (cpu_gnt[g]),
      .cpu_rvalid(cpu_rvalid[g]),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_stall (cpu_stall[g]),
      .dbg_req   (dbg_req[g]),
      .dbg_we    (dbg_we[g]),
      .dbg_addr  (dbg_addr[g]),
      .dbg_wdata (dbg_wdata[g]),
      .dbg_gnt   (dbg_gnt[g]),
      .dbg_rvalid(dbg_rvalid[g]),
      .dbg_rdata (dbg_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Memory model: read data is valid only in the cycle GL cycles after the
    // mem_en cycle; any other cycle shows junk.
    logic [31:0] mem [64];
    bit          wr  [64];
    int          cyc = 0;
    int          due = -1;
    logic [31:0] val;

    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en[g]) begin
        if (mem_we[g]) begin
          mem[mem_addr[g][7:2]] <= mem_wdata[g];
          wr[mem_addr[g][7:2]]  <= 1'b1;
        end else begin
          val <= wr[mem_addr[g][7:2]] ? mem[mem_addr[g][7:2]] : init_word(int'(mem_addr[g][7:2]));
          due <= cyc + GL;
        end
      end
    end

    assign mem_rdata[g] = (cyc == due) ? val : {cyc[15:0], 16'hA5A5};
  end

  // ---------------------------------------------------------------- model
  int          checks = 0;
  int          errors = 0;
  int          k, L, p;
  bit          act, a_own, a_we, last_own;
  int          t_cap, next_ok;
  logic [31:0] a_addr, a_wdata, exp_addr, exp_wdata;
  logic [31:0] exp_rdata [2];
  logic [31:0] refm [2][64];
  bit          pv [2], pg [2], pwe [2];
  logic [31:0] paddr [2], pwdata [2];
  int          obs_gnt_p [2], obs_rv_p [2];
  int          win_log [$];
  bit          auto_reload = 1'b0, rand_mode = 1'b0;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: actual %h expected %h", nm, k, p, got, exp);
    end
  endtask

  task automatic model_reset();
    act = 0; last_own = 1; next_ok = p;
    exp_addr = 0; exp_wdata = 0; exp_rdata[0] = 0; exp_rdata[1] = 0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pg[i] = 0; obs_gnt_p[i] = -1; obs_rv_p[i] = -1;
    end
  endtask

  task automatic load_cmd(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
    pv[i] = 1; pg[i] = 0; pwe[i] = we; paddr[i] = a; pwdata[i] = d;
  endtask

  task automatic load_rand(input int i, input bit rd_only);
    logic [31:0] hi;
    int idx;
    hi  = $urandom();
    idx = $urandom_range(0, 63);
    load_cmd(i, rd_only ? 1'b0 : 1'($urandom_range(0, 1)),
             (hi & 32'hFFFF_FF00) | (32'(idx) << 2), $urandom());
  endtask

  task automatic drive();
    bit r; logic w; logic [31:0] a, d;
    for (int i = 0; i < 2; i++) begin
      r = pv[i] && !pg[i];
      if (r) begin w = pwe[i]; a = paddr[i]; d = pwdata[i]; end
      else begin w = 1'($urandom_range(0, 1)); a = $urandom(); d = $urandom(); end
      if (i == 0) begin cpu_req[k] = r; cpu_we[k] = w; cpu_addr[k] = a; cpu_wdata[k] = d; end
      else        begin dbg_req[k] = r; dbg_we[k] = w; dbg_addr[k] = a; dbg_wdata[k] = d; end
    end
  endtask

  // One clock cycle: drive, compare against the timing model, decide capture.
  // Entered and left on a falling edge.
  task automatic step();
    bit e_issue, e_resp, e_busy, w;
    for (int i = 0; i < 2; i++)
      if (!pv[i] && (auto_reload || (rand_mode && $urandom_range(0, 2) == 0)))
        load_rand(i, auto_reload);
    drive();
    #1;
    e_issue = act && (p == t_cap + 1);
    e_resp  = act && (p == t_cap + 2 + L);
    e_busy  = act && (p >= t_cap + 1) && (p <= t_cap + 1 + L);
    if (e_issue) begin exp_addr = a_addr; exp_wdata = a_wdata; end
    if (e_resp && !a_we) exp_rdata[a_own] = refm[k][a_addr[7:2]];
    chk("cpu_gnt",    cpu_gnt[k],    e_issue && !a_own);
    chk("dbg_gnt",    dbg_gnt[k],    e_issue && a_own);
    chk("cpu_rvalid", cpu_rvalid[k], e_resp && !a_own);
    chk("dbg_rvalid", dbg_rvalid[k], e_resp && a_own);
    chk("mem_en",     mem_en[k],     e_issue);
    chk("mem_we",     mem_we[k],     e_issue && a_we);
    chk("mem_addr",   mem_addr[k],   exp_addr);
    chk("mem_wdata",  mem_wdata[k],  exp_wdata);
    chk("cpu_rdata",  cpu_rdata[k],  exp_rdata[0]);
    chk("dbg_rdata",  dbg_rdata[k],  exp_rdata[1]);
    chk("cpu_stall",  cpu_stall[k],
        (act && !a_own && (p <= t_cap + 2 + L)) ? e_busy : cpu_req[k]);
    if (cpu_gnt[k])    begin obs_gnt_p[0] = p; win_log.push_back(0); end
    if (dbg_gnt[k])    begin obs_gnt_p[1] = p; win_log.push_back(1); end
    if (cpu_rvalid[k]) obs_rv_p[0] = p;
    if (dbg_rvalid[k]) obs_rv_p[1] = p;
    if (e_resp) begin pv[a_own] = 0; pg[a_own] = 0; act = 0; end
    if (!act && p >= next_ok && (cpu_req[k] || dbg_req[k])) begin
      if (cpu_req[k] && dbg_req[k]) begin
`ifdef DMEM_ARB_RR_EN
        w = (last_own == 0);
`else
        w = 0;
`endif
      end else w = dbg_req[k];
      a_own   = w;
      a_we    = w ? dbg_we[k]    : cpu_we[k];
      a_addr  = w ? dbg_addr[k]  : cpu_addr[k];
      a_wdata = w ? dbg_wdata[k] : cpu_wdata[k];
      t_cap = p; act = 1; last_own = w; pg[w] = 1; next_ok = p + L + 3;
      if (a_we) refm[k][a_addr[7:2]] = a_wdata;
    end
    @(posedge clk); p++;
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((pv[0] || pv[1] || act) && n < max) begin step(); n++; end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL timeout dut%0d cycle %0d: actual busy expected idle", k, p);
    end
  endtask

  task automatic do_single(input bit port, input bit we, input logic [31:0] a, input logic [31:0] d);
    int e;
    obs_gnt_p[port] = -1; obs_rv_p[port] = -1;
    load_cmd(port, we, a, d);
    e = p;
    run_until_idle(30);
    chk("lat_gnt",    obs_gnt_p[port] - e, 1);
    chk("lat_rvalid", obs_rv_p[port] - e,  L + 2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cpu_gnt"},    cpu_gnt[k],    0);
    chk({tag, "_dbg_gnt"},    dbg_gnt[k],    0);
    chk({tag, "_cpu_rvalid"}, cpu_rvalid[k], 0);
    chk({tag, "_dbg_rvalid"}, dbg_rvalid[k], 0);
    chk({tag, "_mem_en"},     mem_en[k],     0);
    chk({tag, "_mem_we"},     mem_we[k],     0);
    chk({tag, "_mem_addr"},   mem_addr[k],   0);
    chk({tag, "_mem_wdata"},  mem_wdata[k],  0);
    chk({tag, "_cpu_rdata"},  cpu_rdata[k],  0);
    chk({tag, "_dbg_rdata"},  dbg_rdata[k],  0);
    chk({tag, "_cpu_stall"},  cpu_stall[k],  0);
  endtask

  initial begin
    int exp_win [4];
    int n;
    logic [31:0] got;
`ifdef DMEM_ARB_RR_EN
    exp_win = '{0, 1, 0, 1};
`else
    exp_win = '{0, 0, 0, 0};
`endif
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0055};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 32'hDEADBEEF,  32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_00FC, 32'h1234_5678, 32'h0000_0055};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,         32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hC0DE_0004};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_0001, 32'hC0DE_0004};

    for (int g = 0; g < 2; g++) begin
      cpu_req[g] = 0; cpu_we[g] = 0; cpu_addr[g] = 0; cpu_wdata[g] = 0;
      dbg_req[g] = 0; dbg_we[g] = 0; dbg_addr[g] = 0; dbg_wdata[g] = 0;
      for (int i = 0; i < 64; i++) refm[g][i] = init_word(i);
    end
    reset = 0;
    p = 0;

    for (int kk = 0; kk < 2; kk++) begin
      k = kk;
      L = (kk == 0) ? 1 : 3;

      // Reset state, with requests high to show stall is held low too.
      reset = 0;
      cpu_req[k] = 1; dbg_req[k] = 1;
      repeat (2) @(negedge clk);
      #1 check_all_zero("rst");
      cpu_req[k] = 0; dbg_req[k] = 0;
      @(negedge clk);
      reset = 1;
      model_reset();

      // Single accesses from the vector table.
      foreach (vecs[i]) begin
        do_single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
        got = vecs[i].port ? dbg_rdata[k] : cpu_rdata[k];
        chk("vec_rdata", got, vecs[i].exp_rdata);
      end

      // Both ports requesting continuously: check grant order.
      win_log.delete();
      auto_reload = 1;
      n = 0;
      while (win_log.size() < 4 && n < 200) begin step(); n++; end
      auto_reload = 0;
      run_until_idle(100);
      checks++;
      if (win_log.size() < 4) begin
        errors++;
        $display("FAIL tie_grants dut%0d: actual %0d grants expected 4", k, win_log.size());
      end else begin
        for (int i = 0; i < 4; i++) chk("tie_winner", win_log[i], exp_win[i]);
      end

      // DBG request raised in the CPU's ISSUE cycle.
      for (int i = 0; i < 2; i++) begin obs_gnt_p[i] = -1; obs_rv_p[i] = -1; end
      load_cmd(0, 1'b0, 32'h0000_0008, 32'h0);
      step();
      load_cmd(1, 1'b0, 32'h0000_0010, 32'h0);
      run_until_idle(40);
      chk("late_dbg_spacing", obs_gnt_p[1] - obs_rv_p[0], 2);
      chk("late_cpu_rdata", cpu_rdata[k], 32'hA5A5_0001);
      chk("late_dbg_rdata", dbg_rdata[k], 32'hC0DE_0004);

      // Reset asserted during WAIT.
      load_cmd(0, 1'b0, 32'h0000_0004, 32'h0);
      step();
      step();
      cpu_req[k] = 1;
      #2 reset = 0;
      #1 check_all_zero("mid_rst");
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); p++;
        @(negedge clk);
        chk("mid_rst_no_rvalid", cpu_rvalid[k], 0);
      end
      cpu_req[k] = 0;
      reset = 1;
      model_reset();
      do_single(1'b0, 1'b0, 32'h0000_0008, 32'h0);
      chk("post_rst_rdata", cpu_rdata[k], 32'hA5A5_0001);

      // Randomised traffic checked against the timing model.
      rand_mode = 1;
      repeat (600) step();
      rand_mode = 0;
      run_until_idle(50);

      cpu_req[k] = 0; dbg_req[k] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
